// File: rtl/lib_arb_pkg.sv
// Shared arbiter types and helpers.
// Holds the arbiter state encoding and a width-generic rotate used by round-robin pointers.
package lib_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Widest vector arb_rotl1 can rotate; callers cast in and out of this width.
    localparam int unsigned ArbMaxWidth = 64;

    // Rotate the low `width` bits of vec left by one; bit width-1 wraps to bit 0.
    function automatic logic [ArbMaxWidth-1:0] arb_rotl1(
        input logic [ArbMaxWidth-1:0] vec,
        input int unsigned            width
    );
        logic [ArbMaxWidth-1:0] res;
        res = '0;
        for (int unsigned i = 0; i < ArbMaxWidth - 1; i++) begin
            if (i + 1 < width) begin
                res[i+1] = vec[i];
            end
        end
        res[0] = vec[width-1];
        return res;
    endfunction

endpackage

// File: rtl/lib_ffs.sv
// Find-first-set from a one-hot base, wrapping around the vector.
// LSB_MSB=1 searches upward from base; LSB_MSB=0 searches downward.
module lib_ffs #(
    parameter int unsigned WIDTH   = 4,
    parameter bit          LSB_MSB = 1'b1
) (
    input  logic [WIDTH-1:0] vect_i,
    input  logic [WIDTH-1:0] base_i,
    output logic [WIDTH-1:0] onehot_o
);

    logic [WIDTH-1:0] below_base;
    logic [WIDTH-1:0] hi_part;
    logic [WIDTH-1:0] lo_part;

    function automatic logic [WIDTH-1:0] lowest_set(input logic [WIDTH-1:0] v);
        return v & (~v + WIDTH'(1));
    endfunction

    function automatic logic [WIDTH-1:0] highest_set(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] res;
        res = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (v[i]) begin
                res    = '0;
                res[i] = 1'b1;
            end
        end
        return res;
    endfunction

    // base_i is one-hot, so base-1 marks every bit strictly below it.
    assign below_base = base_i - WIDTH'(1);
    assign hi_part    = vect_i & ~below_base;
    assign lo_part    = vect_i & (below_base | base_i);

    always_comb begin
        onehot_o = '0;
        if (LSB_MSB) begin
            onehot_o = (|hi_part) ? lowest_set(hi_part) : lowest_set(vect_i);
        end else begin
            onehot_o = (|lo_part) ? highest_set(lo_part) : highest_set(vect_i);
        end
    end

endmodule

// File: rtl/lib_rr_arb.sv
// Packet-level round-robin arbiter: one streaming output shared by N valid/ready requesters.
// A winner owns the output until its last beat is accepted; one idle cycle separates packets.
module lib_rr_arb
    import lib_arb_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_valid,
    input  logic [N-1:0]    req_last,
    input  logic [N*DW-1:0] req_data,
    output logic [N-1:0]    req_ready,
    output logic            out_valid,
    output logic            out_last,
    output logic [DW-1:0]   out_data,
    input  logic            out_ready,
    output logic [N-1:0]    grant,
    output logic            busy
);

    arb_state_t    state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [N-1:0]  ptr_q, ptr_d;
    logic [N-1:0]  cand;
    logic          xfer;

    lib_ffs #(
        .WIDTH   (N),
        .LSB_MSB (1'b1)
    ) u_ffs (
        .vect_i   (req_valid),
        .base_i   (ptr_q),
        .onehot_o (cand)
    );

    // grant_q is zero while idle, so every grant-qualified output is quiet then.
    always_comb begin
        out_data = '0;
        out_last = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            out_data = out_data | (req_data[i*DW +: DW] & {DW{grant_q[i]}});
            out_last = out_last | (req_last[i] & grant_q[i]);
        end
    end

    assign out_valid = |(req_valid & grant_q);
    assign req_ready = grant_q & {N{out_ready}};
    assign grant     = grant_q;
    assign busy      = (state_q == ARB_BUSY);
    assign xfer      = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (|req_valid) begin
                    grant_d = cand;
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (xfer && out_last) begin
                    grant_d = '0;
                    state_d = ARB_IDLE;
                    ptr_d   = N'(arb_rotl1(ArbMaxWidth'(grant_q), N));
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            ptr_q   <= N'(1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_lib_rr_arb.sv
// Self-checking bench for lib_rr_arb: directed scenarios plus random traffic,
// checked by a scoreboard fed from a packet-level round-robin reference model.
module tb_lib_rr_arb;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_last;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic            out_last;
    logic [DW-1:0]   out_data;
    logic            out_ready;
    logic [N-1:0]    grant;
    logic            busy;

    always #5 clk = ~clk;

    lib_rr_arb #(
        .N  (N),
        .DW (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_data  (out_data),
        .out_ready (out_ready),
        .grant     (grant),
        .busy      (busy)
    );

    typedef struct {
        logic [DW-1:0] d;
        bit            l;
    } beat_t;

    typedef struct {
        logic [N-1:0]  grant;
        logic          valid;
        logic [DW-1:0] data;
        logic          last;
        logic [N-1:0]  ptr;
        logic [N-1:0]  ready;
    } cyc_t;

    beat_t src_q[N][$];
    cyc_t  cyc_q[$];
    beat_t exp_beats[$];

    // Reference model: owner index and pointer index as plain integers.
    bit m_busy;
    int m_owner;
    int m_ptr;

    logic [N-1:0] en;
    logic         rdy;
    bit           rst_req;
    bit           chk_on;
    int           nerr = 0;
    int           nchk = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_pkt(input int r, input int len, input logic [DW-1:0] base);
        for (int k = 0; k < len; k++) begin
            beat_t b;
            b.d = base + DW'(k);
            b.l = (k == len - 1);
            src_q[r].push_back(b);
        end
    endtask

    task automatic step();
        cyc_t         c;
        logic [N-1:0] v;
        bit           xfer;
        bit           found;
        beat_t        b;
        @(posedge clk);
        #1;
        v = '0;
        for (int i = 0; i < N; i++) begin
            if (en[i] && src_q[i].size() > 0) begin
                v[i]                 = 1'b1;
                req_data[i*DW +: DW] = src_q[i][0].d;
                req_last[i]          = src_q[i][0].l;
            end else begin
                req_data[i*DW +: DW] = DW'($urandom);
                req_last[i]          = 1'($urandom);
            end
        end
        req_valid = v;
        out_ready = rdy;
        rst       = rst_req;

        c.grant = '0;
        c.valid = 1'b0;
        c.data  = '0;
        c.last  = 1'b0;
        c.ptr   = '0;
        c.ptr[m_ptr] = 1'b1;
        if (m_busy) begin
            c.grant[m_owner] = 1'b1;
            c.valid = v[m_owner];
            if (c.valid) begin
                c.data = src_q[m_owner][0].d;
                c.last = src_q[m_owner][0].l;
            end
        end
        c.ready = c.grant & {N{rdy}};
        if (chk_on) cyc_q.push_back(c);

        xfer = c.valid && rdy;
        b.d  = '0;
        b.l  = 1'b0;
        if (xfer) begin
            b = src_q[m_owner].pop_front();
            if (chk_on) exp_beats.push_back(b);
        end

        if (rst_req) begin
            // Upstream drops whatever remains of the interrupted packet.
            if (m_busy && !(xfer && b.l)) begin
                found = 1'b0;
                while (!found && src_q[m_owner].size() > 0) begin
                    b = src_q[m_owner].pop_front();
                    found = b.l;
                end
            end
            m_busy = 1'b0;
            m_ptr  = 0;
        end else if (m_busy) begin
            if (xfer && b.l) begin
                m_busy = 1'b0;
                m_ptr  = (m_owner + 1) % N;
            end
        end else if (v != '0) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (!found && v[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    found   = 1'b1;
                end
            end
            m_busy = 1'b1;
        end
    endtask

    task automatic do_reset();
        rdy     = 1'b0;
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
    endtask

    // Monitor: per-cycle control checks, beat checks on every observed handshake.
    always @(negedge clk) begin
        cyc_t  mc;
        beat_t mb;
        if (cyc_q.size() > 0) begin
            mc = cyc_q.pop_front();
            chk("grant", 32'(grant), 32'(mc.grant));
            chk("busy", 32'(busy), 32'(|mc.grant));
            chk("out_valid", 32'(out_valid), 32'(mc.valid));
            chk("req_ready", 32'(req_ready), 32'(mc.ready));
            chk("ptr", 32'(dut.ptr_q), 32'(mc.ptr));
            chk("ptr_onehot", 32'($onehot(dut.ptr_q)), 32'd1);
            if (mc.valid) begin
                chk("out_data", 32'(out_data), 32'(mc.data));
                chk("out_last", 32'(out_last), 32'(mc.last));
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_beats.size() == 0) begin
                    chk("beat_unexpected", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    mb = exp_beats.pop_front();
                    chk("beat_data", 32'(out_data), 32'(mb.d));
                    chk("beat_last", 32'(out_last), 32'(mb.l));
                end
            end
        end
    end

    initial begin
        int remaining;
        rst       = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        out_ready = 1'b0;
        en        = '0;
        rdy       = 1'b0;
        rst_req   = 1'b1;
        chk_on    = 1'b0;
        m_busy    = 1'b0;
        m_owner   = 0;
        m_ptr     = 0;
        step();
        step();
        rst_req = 1'b0;
        chk_on  = 1'b1;

        // Lone 3-beat packet from req 2.
        en  = 4'b0100;
        rdy = 1'b1;
        push_pkt(2, 3, 8'hA1);
        repeat (6) step();

        // All requesters streaming single-beat packets from reset.
        do_reset();
        for (int j = 0; j < 2; j++) begin
            for (int r = 0; r < N; r++) push_pkt(r, 1, DW'(8'h10 * r + j));
        end
        en  = 4'b1111;
        rdy = 1'b1;
        repeat (18) step();

        // Downstream stall on the first beat.
        en  = 4'b0010;
        rdy = 1'b0;
        push_pkt(1, 2, 8'h31);
        repeat (4) step();
        rdy = 1'b1;
        repeat (4) step();

        // ptr at req 2 with reqs 1 and 3 pending: wrap-around order.
        en = 4'b1010;
        push_pkt(1, 1, 8'h41);
        push_pkt(3, 1, 8'h43);
        repeat (6) step();

        // Owner drops valid mid-packet while another requester waits.
        push_pkt(0, 3, 8'h50);
        push_pkt(2, 1, 8'h52);
        en = 4'b0001;
        step();
        en = 4'b0101;
        step();
        en = 4'b0100;
        step();
        step();
        en = 4'b0101;
        repeat (8) step();

        // Reset during the second beat of a 4-beat packet.
        en  = 4'b1000;
        rdy = 1'b1;
        push_pkt(3, 4, 8'h60);
        step();
        step();
        do_reset();
        rdy = 1'b1;
        step();
        push_pkt(3, 2, 8'h70);
        repeat (5) step();

        // Random traffic.
        for (int t = 0; t < 400; t++) begin
            en  = N'($urandom);
            rdy = ($urandom_range(0, 9) < 7);
            for (int r = 0; r < N; r++) begin
                if (src_q[r].size() < 3 && $urandom_range(0, 3) == 0) begin
                    push_pkt(r, $urandom_range(1, 4), DW'($urandom));
                end
            end
            step();
        end

        // Drain everything still queued.
        en  = '1;
        rdy = 1'b1;
        for (int t = 0; t < 300; t++) begin
            remaining = 0;
            for (int r = 0; r < N; r++) remaining += src_q[r].size();
            if (remaining == 0) break;
            step();
        end
        repeat (3) step();
        remaining = 0;
        for (int r = 0; r < N; r++) remaining += src_q[r].size();
        chk("drain_timeout", 32'(remaining), 32'd0);
        @(negedge clk);
        #1;
        chk("beats_outstanding", 32'(exp_beats.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
